// File: rtl/hdmi_in_cfg_seq.sv
// rtl/hdmi_in_cfg_seq.sv - HDMI receiver reset and I2C register table sequencer
//
// On start_i, holds the HDMI receiver in reset, waits for it to settle, then
// walks a register table ROM. Each entry is either a register write, a delay
// or an end marker. Each write is issued to an external I2C master and retried
// on NACK up to MAX_RETRY times before the run gives up.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   start_i             one-cycle pulse that starts a run (IDLE/DONE/ERROR only)
//   vin_rst_no          active-low reset to the HDMI receiver
//   tbl_addr_o          table ROM address
//   tbl_data_i          {dev, reg, val}, valid one cycle after tbl_addr_o changes
//   i2c_req_o           write request, held until ack/nack
//   i2c_dev_o/reg_o/val_o  write fields
//   i2c_ack_i/nack_i    one-cycle completion pulses
//   busy_o/done_o/err_o run status
//   err_addr_o          table index that caused the error
module hdmi_in_cfg_seq #(
  parameter int RST_CYCLES    = 1000,
  parameter int SETTLE_CYCLES = 10000,
  parameter int DLY_UNIT      = 1000,
  parameter int MAX_RETRY     = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        vin_rst_no,
  output logic [7:0]  tbl_addr_o,
  input  logic [23:0] tbl_data_i,
  output logic        i2c_req_o,
  output logic [6:0]  i2c_dev_o,
  output logic [7:0]  i2c_reg_o,
  output logic [7:0]  i2c_val_o,
  input  logic        i2c_ack_i,
  input  logic        i2c_nack_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [7:0]  err_addr_o
);

  localparam int DLY_MAX  = 255 * DLY_UNIT;
  localparam int CNT_MAX0 = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int CNT_MAX  = (CNT_MAX0 > DLY_MAX) ? CNT_MAX0 : DLY_MAX;
  localparam int CW       = $clog2(CNT_MAX + 1);
  localparam int RW       = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  // Counters load "length - 1" and count down to zero, so a phase of N
  // cycles occupies exactly N cycles in its state.
  localparam logic [CW-1:0] RST_LOAD    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] DLY_UNIT_W  = CW'(DLY_UNIT);
  localparam logic [RW-1:0] MAX_RETRY_W = RW'(MAX_RETRY);

  localparam logic [7:0] DEV_END   = 8'hFF;
  localparam logic [7:0] DEV_DELAY = 8'hFE;

  typedef enum logic [3:0] {
    S_IDLE, S_RESET, S_SETTLE, S_FETCH, S_DECODE, S_WRITE, S_DELAY, S_DONE, S_ERROR
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [CW-1:0]   dly_total;
  logic            advance;

  logic            vin_d, req_d, busy_d, done_d, err_d;
  logic [7:0]      addr_d, reg_d, val_d, err_addr_d;
  logic [6:0]      dev_d;

  assign dly_total = CW'(tbl_data_i[7:0]) * DLY_UNIT_W;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    retry_d    = retry_q;
    vin_d      = vin_rst_no;
    addr_d     = tbl_addr_o;
    req_d      = i2c_req_o;
    dev_d      = i2c_dev_o;
    reg_d      = i2c_reg_o;
    val_d      = i2c_val_o;
    busy_d     = busy_o;
    done_d     = done_o;
    err_d      = err_o;
    err_addr_d = err_addr_o;
    advance    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_i) begin
          state_d = S_RESET;
          cnt_d   = RST_LOAD;
          retry_d = '0;
          vin_d   = 1'b0;
          addr_d  = 8'd0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end

      S_RESET: begin
        if (cnt_q == '0) begin
          state_d = S_SETTLE;
          cnt_d   = SETTLE_LOAD;
          vin_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_FETCH;
        else             cnt_d   = cnt_q - CW'(1);
      end

      // ROM sees the new address during FETCH; its data is valid in DECODE.
      S_FETCH: state_d = S_DECODE;

      S_DECODE: begin
        if (tbl_data_i[23:16] == DEV_END) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (tbl_data_i[23:16] == DEV_DELAY) begin
          if (dly_total == '0) begin
            advance = 1'b1;
          end else begin
            state_d = S_DELAY;
            cnt_d   = dly_total - CW'(1);
          end
        end else begin
          state_d = S_WRITE;
          retry_d = '0;
          req_d   = 1'b1;
          dev_d   = tbl_data_i[22:16];
          reg_d   = tbl_data_i[15:8];
          val_d   = tbl_data_i[7:0];
        end
      end

      S_DELAY: begin
        if (cnt_q == '0) advance = 1'b1;
        else             cnt_d   = cnt_q - CW'(1);
      end

      // A WRITE cycle with the request low is the one-cycle gap before a
      // retry; completion pulses are only honoured while the request is up.
      // NACK takes priority so a simultaneous ACK+NACK is retried.
      S_WRITE: begin
        if (!i2c_req_o) begin
          req_d = 1'b1;
        end else if (i2c_nack_i) begin
          req_d = 1'b0;
          if (retry_q < MAX_RETRY_W) begin
            retry_d = retry_q + RW'(1);
          end else begin
            state_d    = S_ERROR;
            err_d      = 1'b1;
            busy_d     = 1'b0;
            err_addr_d = tbl_addr_o;
          end
        end else if (i2c_ack_i) begin
          req_d   = 1'b0;
          retry_d = '0;
          advance = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Moving past the last ROM slot without an end marker is a table error.
    if (advance) begin
      if (tbl_addr_o == 8'hFF) begin
        state_d    = S_ERROR;
        err_d      = 1'b1;
        busy_d     = 1'b0;
        err_addr_d = 8'hFF;
      end else begin
        state_d = S_FETCH;
        addr_d  = tbl_addr_o + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      retry_q    <= '0;
      vin_rst_no <= 1'b0;
      tbl_addr_o <= 8'd0;
      i2c_req_o  <= 1'b0;
      i2c_dev_o  <= 7'd0;
      i2c_reg_o  <= 8'd0;
      i2c_val_o  <= 8'd0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      err_addr_o <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      vin_rst_no <= vin_d;
      tbl_addr_o <= addr_d;
      i2c_req_o  <= req_d;
      i2c_dev_o  <= dev_d;
      i2c_reg_o  <= reg_d;
      i2c_val_o  <= val_d;
      busy_o     <= busy_d;
      done_o     <= done_d;
      err_o      <= err_d;
      err_addr_o <= err_addr_d;
    end
  end

endmodule

// File: tb/tb_hdmi_in_cfg_seq.sv
// tb/tb_hdmi_in_cfg_seq.sv - self-checking bench for hdmi_in_cfg_seq
module tb_hdmi_in_cfg_seq;

  localparam int RST_N    = 4;
  localparam int SETTLE_N = 8;
  localparam int DLY_U    = 5;
  localparam int RETRIES  = 3;
  localparam int RESP_DLY = 3;

  localparam int M_ACK       = 0;
  localparam int M_NACK_ADDR = 1;
  localparam int M_BOTH_ONCE = 2;
  localparam int M_SILENT    = 3;

  logic        clk, rst_i, start_i;
  logic        vin_rst_no;
  logic [7:0]  tbl_addr_o;
  logic [23:0] tbl_data;
  logic        i2c_req_o;
  logic [6:0]  i2c_dev_o;
  logic [7:0]  i2c_reg_o, i2c_val_o;
  logic        i2c_ack, i2c_nack;
  logic        busy_o, done_o, err_o;
  logic [7:0]  err_addr_o;

  hdmi_in_cfg_seq #(
    .RST_CYCLES(RST_N), .SETTLE_CYCLES(SETTLE_N), .DLY_UNIT(DLY_U), .MAX_RETRY(RETRIES)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .vin_rst_no(vin_rst_no),
    .tbl_addr_o(tbl_addr_o), .tbl_data_i(tbl_data), .i2c_req_o(i2c_req_o),
    .i2c_dev_o(i2c_dev_o), .i2c_reg_o(i2c_reg_o), .i2c_val_o(i2c_val_o),
    .i2c_ack_i(i2c_ack), .i2c_nack_i(i2c_nack), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .err_addr_o(err_addr_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous table ROM: data follows the address by one cycle.
  logic [23:0] rom [256];
  always @(posedge clk) tbl_data <= rom[tbl_addr_o];

  typedef struct {
    logic [6:0] dev;
    logic [7:0] rg;
    logic [7:0] val;
    logic [7:0] addr;
    int         gap;
  } req_t;

  typedef struct {
    logic [23:0] entry;
    logic        wr;
    logic [6:0]  dev;
    logic [7:0]  rg;
    logic [7:0]  val;
  } vec_t;

  req_t reqs[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   resp_mode = M_ACK;
  logic [7:0] nack_addr = 8'd0;
  bit   both_pending = 1'b0;
  int   low_run = 0;
  int   vin_low, pre_req, busy_at_start, err_at_start, done_at_start;
  bit   saw_req;
  int   addr_hist [256];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // I2C master model: answers each request RESP_DLY cycles after it rises
  // and logs every request with the number of low cycles preceding it.
  initial begin : i2c_model
    int   age;
    bit   req_prev;
    req_t r;
    age = 0;
    req_prev = 1'b0;
    i2c_ack = 1'b0;
    i2c_nack = 1'b0;
    forever begin
      @(negedge clk);
      i2c_ack = 1'b0;
      i2c_nack = 1'b0;
      if (i2c_req_o) begin
        if (!req_prev) begin
          r.dev = i2c_dev_o; r.rg = i2c_reg_o; r.val = i2c_val_o;
          r.addr = tbl_addr_o; r.gap = low_run;
          reqs.push_back(r);
          age = 0;
        end
        age++;
        low_run = 0;
        if (age == RESP_DLY) begin
          case (resp_mode)
            M_ACK: i2c_ack = 1'b1;
            M_NACK_ADDR: begin
              if (tbl_addr_o == nack_addr) i2c_nack = 1'b1;
              else                         i2c_ack = 1'b1;
            end
            M_BOTH_ONCE: begin
              i2c_ack = 1'b1;
              if (both_pending) begin
                i2c_nack = 1'b1;
                both_pending = 1'b0;
              end
            end
            default: ;
          endcase
        end
      end else begin
        low_run++;
      end
      req_prev = i2c_req_o;
    end
  end

  task automatic fill_rom(input logic [23:0] v);
    for (int i = 0; i < 256; i++) rom[i] = v;
  endtask

  task automatic run(input string nm, input int budget);
    int n;
    reqs.delete();
    low_run = 0; vin_low = 0; pre_req = 0; saw_req = 1'b0;
    for (int i = 0; i < 256; i++) addr_hist[i] = 0;
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    busy_at_start = int'(busy_o);
    err_at_start  = int'(err_o);
    done_at_start = int'(done_o);
    n = 0;
    while (!(done_o || err_o) && n < budget) begin
      if (!vin_rst_no) vin_low++;
      else if (!saw_req && !i2c_req_o) pre_req++;
      if (i2c_req_o) saw_req = 1'b1;
      addr_hist[tbl_addr_o]++;
      @(negedge clk);
      n++;
    end
    chk({nm, "_finished"}, 32'(n < budget), 32'd1);
  endtask

  vec_t vecs [4];

  initial begin
    int k;
    vecs[0] = '{24'h480001, 1'b1, 7'h48, 8'h00, 8'h01};
    vecs[1] = '{24'h480102, 1'b1, 7'h48, 8'h01, 8'h02};
    vecs[2] = '{24'hC87FAA, 1'b1, 7'h48, 8'h7F, 8'hAA};
    vecs[3] = '{24'hFF0000, 1'b0, 7'h00, 8'h00, 8'h00};

    rst_i = 1'b1;
    start_i = 1'b0;
    fill_rom(24'hFF0000);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_vin", 32'(vin_rst_no), 32'd0);
    chk("rst_req", 32'(i2c_req_o), 32'd0);
    chk("rst_status", {29'd0, busy_o, done_o, err_o}, 32'd0);
    chk("rst_addr", 32'(tbl_addr_o), 32'd0);
    chk("rst_err_addr", 32'(err_addr_o), 32'd0);
    rst_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_hold", {29'd0, busy_o, vin_rst_no, i2c_req_o}, 32'd0);

    // Table-driven run: writes must appear in table order with dev[7] dropped
    resp_mode = M_ACK;
    fill_rom(24'hFF0000);
    for (int i = 0; i < 4; i++) rom[i] = vecs[i].entry;
    run("t1", 500);
    chk("t1_busy_start", 32'(busy_at_start), 32'd1);
    chk("t1_vin_low", 32'(vin_low), 32'(RST_N));
    chk("t1_settle", 32'(pre_req), 32'(SETTLE_N + 2));
    k = 0;
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].wr) begin
        if (k < reqs.size()) begin
          chk($sformatf("t1_dev%0d", i), 32'(reqs[k].dev), 32'(vecs[i].dev));
          chk($sformatf("t1_reg%0d", i), 32'(reqs[k].rg), 32'(vecs[i].rg));
          chk($sformatf("t1_val%0d", i), 32'(reqs[k].val), 32'(vecs[i].val));
          chk($sformatf("t1_addr%0d", i), 32'(reqs[k].addr), 32'(i));
        end else begin
          chk($sformatf("t1_present%0d", i), 32'd0, 32'd1);
        end
        k++;
      end
    end
    chk("t1_count", 32'(reqs.size()), 32'(k));
    chk("t1_final", {28'd0, vin_rst_no, busy_o, done_o, err_o}, 32'b1010);

    // Delay entries: FE_00_03 holds its address for FETCH+DECODE+3*DLY_U
    fill_rom(24'hFF0000);
    rom[0] = 24'h480001; rom[1] = 24'hFE0003; rom[2] = 24'h480205;
    rom[3] = 24'hFE0000; rom[4] = 24'hFF0000;
    run("t2", 500);
    chk("t2_done", 32'(done_o), 32'd1);
    chk("t2_count", 32'(reqs.size()), 32'd2);
    chk("t2_dly3_cycles", 32'(addr_hist[1]), 32'(2 + 3 * DLY_U));
    chk("t2_dly0_cycles", 32'(addr_hist[3]), 32'd2);
    if (reqs.size() == 2) begin
      chk("t2_gap", 32'(reqs[1].gap), 32'(2 + 3 * DLY_U + 2));
      chk("t2_addr", 32'(reqs[1].addr), 32'd2);
    end

    // Persistent NACK on entry 1: 1 + RETRIES requests, then ERROR
    fill_rom(24'hFF0000);
    rom[0] = 24'h480001; rom[1] = 24'h480507; rom[2] = 24'hFF0000;
    resp_mode = M_NACK_ADDR; nack_addr = 8'd1;
    run("t3", 500);
    chk("t3_count", 32'(reqs.size()), 32'(2 + RETRIES));
    if (reqs.size() == 2 + RETRIES) begin
      chk("t3_last_addr", 32'(reqs[RETRIES + 1].addr), 32'd1);
      chk("t3_last_fields", {9'd0, reqs[RETRIES + 1].dev, reqs[RETRIES + 1].rg,
          reqs[RETRIES + 1].val}, 32'h00480507);
      chk("t3_retry_gap", 32'(reqs[RETRIES + 1].gap), 32'd1);
    end
    chk("t3_status", {29'd0, busy_o, done_o, err_o}, 32'b001);
    chk("t3_err_addr", 32'(err_addr_o), 32'd1);
    repeat (3) @(negedge clk);
    chk("t3_req_quiet", 32'(i2c_req_o), 32'd0);

    // Simultaneous ACK+NACK is a NACK: same fields re-issued after one low cycle
    fill_rom(24'hFF0000);
    rom[0] = 24'h480001;
    resp_mode = M_BOTH_ONCE; both_pending = 1'b1;
    run("t4", 500);
    chk("t4_from_err", {30'd0, 1'(busy_at_start), 1'(err_at_start)}, 32'b10);
    chk("t4_count", 32'(reqs.size()), 32'd2);
    if (reqs.size() == 2) begin
      chk("t4_gap", 32'(reqs[1].gap), 32'd1);
      chk("t4_fields", {9'd0, reqs[1].dev, reqs[1].rg, reqs[1].val}, 32'h00480001);
    end
    chk("t4_done", 32'(done_o), 32'd1);

    // No end marker: 256 ACKed writes, then ERROR at 255 without wrapping
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = 8'(i);
      rom[i] = {8'h20, b, ~b};
    end
    resp_mode = M_ACK;
    run("t5", 4000);
    chk("t5_from_done", 32'(done_at_start), 32'd0);
    chk("t5_count", 32'(reqs.size()), 32'd256);
    if (reqs.size() == 256) begin
      chk("t5_last", {reqs[255].addr, 1'b0, reqs[255].dev, reqs[255].rg, reqs[255].val},
          32'hFF20FF00);
    end
    chk("t5_status", {29'd0, busy_o, done_o, err_o}, 32'b001);
    chk("t5_err_addr", 32'(err_addr_o), 32'd255);

    // Reset during an outstanding request, then a clean restart
    fill_rom(24'hFF0000);
    rom[0] = 24'h480001; rom[1] = 24'h480102; rom[2] = 24'hFF0000;
    resp_mode = M_SILENT;
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    k = 0;
    while (!i2c_req_o && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t6_req_seen", 32'(i2c_req_o), 32'd1);
    #1 rst_i = 1'b1;
    #1 chk("t6_async_req", 32'(i2c_req_o), 32'd0);
    chk("t6_rst_outs", {vin_rst_no, busy_o, done_o, err_o, tbl_addr_o, err_addr_o},
        32'd0);
    chk("t6_rst_fields", {9'd0, i2c_dev_o, i2c_reg_o, i2c_val_o}, 32'd0);
    @(negedge clk); rst_i = 1'b0;
    resp_mode = M_ACK;
    repeat (5) @(negedge clk);
    chk("t6_idle", {30'd0, busy_o, i2c_req_o}, 32'd0);
    run("t6", 500);
    chk("t6_vin_low", 32'(vin_low), 32'(RST_N));
    chk("t6_count", 32'(reqs.size()), 32'd2);
    if (reqs.size() == 2) begin
      chk("t6_first", {reqs[0].addr, 1'b0, reqs[0].dev, reqs[0].rg, reqs[0].val},
          32'h00480001);
      chk("t6_second", {reqs[1].addr, 1'b0, reqs[1].dev, reqs[1].rg, reqs[1].val},
          32'h01480102);
    end
    chk("t6_done", {29'd0, busy_o, done_o, err_o}, 32'b010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hdmi_in_cfg_seq.md
HDMI_IN_CFG_SEQ -- requirements
Module: hdmi_in_cfg_seq

Interface
REQ-001 Parameter RST_CYCLES, default 1000, SHALL set the number of cycles vin_rst_no is held low.
REQ-002 Parameter SETTLE_CYCLES, default 10000, SHALL set the number of cycles waited after reset release before the first table fetch.
REQ-003 Parameter DLY_UNIT, default 1000, SHALL set the cycles per delay tick of a delay entry.
REQ-004 Parameter MAX_RETRY, default 3, SHALL set the number of re-issues allowed after a NACK, per entry.
REQ-005 Port clk_i, input, 1 bit: sole clock; all logic is rising-edge.
REQ-006 Port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-007 Port start_i, input, 1 bit: single-cycle pulse that begins a configuration run.
REQ-008 Port vin_rst_no, output, 1 bit: active-low reset to the HDMI receiver.
REQ-009 Port tbl_addr_o, output, 8 bits: table ROM address.
REQ-010 Port tbl_data_i, input, 24 bits: {dev[7:0], reg[7:0], val[7:0]}, valid exactly one cycle after tbl_addr_o changes.
REQ-011 Port i2c_req_o, output, 1 bit: write request to the external I2C master.
REQ-012 Port i2c_dev_o, output, 7 bits; i2c_reg_o, output, 8 bits; i2c_val_o, output, 8 bits: write fields.
REQ-013 Port i2c_ack_i / i2c_nack_i, inputs, 1 bit each: one-cycle completion pulses from the I2C master.
REQ-014 Ports busy_o, done_o, err_o, outputs, 1 bit each: status; err_addr_o, output, 8 bits: failing table index.

Function
REQ-015 States SHALL be IDLE, RESET, SETTLE, FETCH, DECODE, WRITE, DELAY, DONE, ERROR.
REQ-016 A start_i pulse in IDLE, DONE or ERROR SHALL enter RESET next cycle, clear done_o, err_o and tbl_addr_o, and assert busy_o; start_i SHALL be ignored in every other state.
REQ-017 In RESET, vin_rst_no SHALL be 0 for exactly RST_CYCLES cycles, then go 1 on entry to SETTLE.
REQ-018 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then enter FETCH.
REQ-019 FETCH SHALL last one cycle with tbl_addr_o stable; DECODE SHALL sample tbl_data_i in the next cycle.
REQ-020 In DECODE, dev == 8'hFF (end marker) SHALL enter DONE.
REQ-021 In DECODE, dev == 8'hFE SHALL enter DELAY for val*DLY_UNIT cycles (zero cycles when val = 0), then increment the address and enter FETCH.
REQ-022 In DECODE, any other dev SHALL enter WRITE with i2c_dev_o = dev[6:0] (dev[7] ignored), and i2c_reg_o and i2c_val_o loaded from the entry.
REQ-023 In WRITE, i2c_req_o SHALL be 1 with all fields stable until a cycle where i2c_ack_i or i2c_nack_i is 1; i2c_req_o SHALL be 0 in the following cycle.
REQ-024 On ACK, the retry count SHALL clear, tbl_addr_o SHALL increment, and the FSM SHALL enter FETCH.
REQ-025 ACK and NACK asserted in the same cycle SHALL be treated as NACK.
REQ-026 On NACK with retry count < MAX_RETRY, the count SHALL increment, i2c_req_o SHALL stay low for one cycle, then re-assert with the same fields.
REQ-027 On NACK with retry count == MAX_RETRY, the FSM SHALL enter ERROR with err_addr_o = tbl_addr_o.
REQ-028 An increment from tbl_addr_o = 255 without an end marker SHALL enter ERROR with err_addr_o = 255, with no wrap to 0.
REQ-029 In DONE, done_o SHALL be 1 and busy_o 0; in ERROR, err_o SHALL be 1 and busy_o 0; vin_rst_no SHALL remain 1 in both.
REQ-030 Delay and wait counters SHALL be wide enough for SETTLE_CYCLES and 255*DLY_UNIT without overflow.

Reset
REQ-031 While rst_i = 1, regardless of state, the block SHALL force IDLE, vin_rst_no = 0, i2c_req_o = 0, busy_o/done_o/err_o = 0, tbl_addr_o = 0, err_addr_o = 0, all fields and counters = 0.
REQ-032 After rst_i deasserts, the block SHALL remain in IDLE until start_i.
REQ-033 rst_i asserted mid-transaction SHALL drop i2c_req_o asynchronously, with no completion pending afterwards.

Verification
REQ-034 Table {48_00_01, 48_01_02, FF_00_00}, RST_CYCLES=4, SETTLE_CYCLES=8, every write ACKed 3 cycles after req -> vin_rst_no low for exactly 4 cycles, two writes issued in order, done_o=1, no third write.
REQ-035 Entry FE_00_03 with DLY_UNIT=5 -> exactly 15 idle cycles between the preceding ACK-driven FETCH path and the next FETCH.
REQ-036 MAX_RETRY=3, device always NACKs entry 1 -> 4 requests for entry 1, then err_o=1, err_addr_o=1, busy_o=0.
REQ-037 Single cycle with ack and nack both 1 -> retry taken, same fields re-issued after 1 low cycle.
REQ-038 Table with no end marker -> ERROR with err_addr_o=255 after 256 ACKed writes.
REQ-039 rst_i pulse while i2c_req_o=1, then start_i -> all outputs at reset values, full sequence restarts from address 0.
